fan_out_in_pipe: RTL
====================

Name: fan_out_in_pipe

Overview:
- Parametrised fan-out/fan-in block. One input beat is broadcast to N_CHANNELS per-channel register pipelines.
- Channel outputs are recombined by a selectable bitwise reduction (OR/AND/XOR) into a registered output beat.
- A valid/ready handshake with whole-pipeline stall is added, plus a per-beat channel enable mask.
- Used as the structural successor for multi-instance fan-out/fan-in path tests, with configurable width, channel count and depth.

Parameters:
- WIDTH, 8, data bits per channel and output.
- N_CHANNELS, 3, number of parallel channel pipelines (>=1).
- DEPTH, 2, register stages per channel (>=1).
- REDUCE_OP, OP_OR, reduction: OP_OR, OP_AND or OP_XOR (type reduce_op_e).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts input this cycle.
- in_data  input  WIDTH  data broadcast to all channels.
- in_chan_en  input  N_CHANNELS  per-beat channel enable mask.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts output.
- out_data  output  WIDTH  reduced result.
- out_chan_en  output  N_CHANNELS  enable mask that produced out_data.
- beat_count  output  16  count of output beats accepted downstream.

Behaviour:
- Reset (asynchronous, active-high):
  - all stage valid bits, stage data, out_valid, out_data, out_chan_en and beat_count clear to 0.
  - in_ready = 1 once rst is deasserted.
- Stall and transfer:
  - stall = out_valid && !out_ready. in_ready = !stall (combinational).
  - Input accepted when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While stall = 1, every stage and the output register hold.
- Channel pipelines:
  - Each channel has DEPTH stages carrying (valid, data, en bit).
  - Stage 0 loads in_data on acceptance, with en = in_chan_en[i].
  - When not stalled, each stage advances every cycle; bubbles propagate as valid = 0.
- Reduction:
  - The identity element is 0 for OR/XOR and all-ones for AND.
  - A disabled channel contributes the identity element.
  - The result is registered into out_data when not stalled.
- out_valid:
  - Set when the last stage is valid and its carried mask has at least one bit set.
  - An all-zero mask beat is dropped: it produces a bubble, out_valid = 0 and out_data is held.
- Latency: DEPTH+1 cycles from acceptance to out_valid, with no stalls.
  - Full throughput of 1 beat/cycle while out_ready = 1.
- All channels advance in lockstep, so channel last stages are always aligned. A stage valid bit is shared across channels (per-channel valids are redundant).
- beat_count increments by 1 per output transfer and wraps 0xFFFF -> 0x0000.
- Simultaneous events:
  - Output transfer plus new acceptance in the same cycle is legal; the pipeline shifts.
  - Reset mid-stream discards all in-flight beats; no partial output.
- Example: with WIDTH=8 and REDUCE_OP=OP_AND, if only channel 1 is enabled, out_data equals the input data.

Decomposition:
- fan_out_in_pkg:
  - reduce_op_e enum {OP_OR, OP_AND, OP_XOR}.
  - function reduce_identity(op) returning the WIDTH-independent fill bit.
  - beat count width constant BEAT_CNT_W = 16.
- Sub-module fan_out_in_stage:
  - one channel's DEPTH-deep register chain with hold input.
  - parameters WIDTH and DEPTH.
  - instantiated N_CHANNELS times via generate.
- Top level owns the handshake, the reduction register and beat_count.

Test Plan:
1. Defaults (OR), out_ready=1. Send 0x01 with mask 3'b111 at cycle 0 -> out_valid at cycle 3, out_data=0x01, out_chan_en=3'b111, beat_count=1.
2. REDUCE_OP=OP_AND, mask 3'b010, in_data 0x5A -> out_data=0x5A. Next beat, mask 3'b000 -> no out_valid for that beat, out_data holds 0x5A.
3. REDUCE_OP=OP_XOR, mask 3'b101, in_data 0xFF -> out_data=0x00. Mask 3'b111, 0xFF -> out_data=0xFF.
4. Back-to-back beats 0x10..0x17, with out_ready low for cycles 4-6:
   - in_ready low exactly while out_valid && !out_ready.
   - all 8 beats appear in order, none lost or duplicated, beat_count=8.
5. Assert rst asynchronously mid-edge with 2 beats in flight:
   - out_valid, out_data and beat_count go to 0 immediately.
   - no stale beat emerges after reset release.
6. Preload beat_count to 0xFFFE via 3 transfers from forced start (or a long run) -> counter reads 0xFFFF, then 0x0000.

Source files
------------

// File: rtl/fan_out_in_pkg.sv
// Shared types and constants for the fan-out/fan-in pipeline.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fan_out_in_pkg;

    // Bitwise reduction applied across the channel pipelines
    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_XOR = 2'd2
    } reduce_op_e;

    localparam int BEAT_CNT_W = 16;

    // Fill bit of the reduction identity: all-ones for AND, zero for OR/XOR.
    // A disabled channel contributes this value replicated across the word.
    function automatic logic reduce_identity(input reduce_op_e op);
        return (op == OP_AND);
    endfunction

endpackage

// File: rtl/fan_out_in_stage.sv
// One channel's DEPTH-deep register chain carrying (data, enable bit).
// Latency: DEPTH cycles from in_* to out_*; advances every cycle hold is low.
// Backpressure: hold=1 freezes every stage; validity is tracked by the parent.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   hold              freeze the whole chain this cycle
//   in_data, in_en    stage-0 load value and channel enable bit
//   out_data, out_en  last-stage contents
module fan_out_in_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_en
);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            en_q, en_d;

    // Stage 0 loads unconditionally when not held; a bubble is marked by the
    // shared valid chain in the parent, so the data content is don't-care.
    always_comb begin
        data_d = data_q;
        en_d   = en_q;
        if (!hold) begin
            data_d[0] = in_data;
            en_d[0]   = in_en;
            for (int k = 1; k < DEPTH; k++) begin
                data_d[k] = data_q[k-1];
                en_d[k]   = en_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            en_q   <= '0;
        end else begin
            data_q <= data_d;
            en_q   <= en_d;
        end
    end

    assign out_data = data_q[DEPTH-1];
    assign out_en   = en_q[DEPTH-1];

endmodule

// File: rtl/fan_out_in_pipe.sv
// Broadcasts each accepted beat to N_CHANNELS pipelines and reduces them (OR/AND/XOR) into a registered output beat.
// Latency: DEPTH+1 cycles from acceptance to out_valid; 1 beat/cycle while out_ready=1.
// Backpressure: stall = out_valid && !out_ready freezes all stages and the output; in_ready = !stall.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         input handshake
//   in_data, in_chan_en       beat data (broadcast) and per-beat channel enable mask
//   out_valid/out_ready       output handshake
//   out_data, out_chan_en     reduced result and the mask that produced it
//   beat_count                output transfers accepted downstream (wraps)
module fan_out_in_pipe
    import fan_out_in_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter int         N_CHANNELS = 3,
    parameter int         DEPTH      = 2,
    parameter reduce_op_e REDUCE_OP  = OP_OR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [N_CHANNELS-1:0] in_chan_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [N_CHANNELS-1:0] out_chan_en,
    output logic [BEAT_CNT_W-1:0] beat_count
);

    localparam logic [WIDTH-1:0] FILL = {WIDTH{reduce_identity(REDUCE_OP)}};

    logic stall;
    logic accept;

    // Channels advance in lockstep, so one valid bit per stage covers all of them
    logic [DEPTH-1:0] vld_q, vld_d;

    logic [N_CHANNELS-1:0][WIDTH-1:0] ch_data;
    logic [N_CHANNELS-1:0]            ch_en;

    logic [WIDTH-1:0] red_val;
    logic [WIDTH-1:0] term;
    logic             beat_ok;

    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [N_CHANNELS-1:0] out_chan_en_q, out_chan_en_d;
    logic [BEAT_CNT_W-1:0] beat_count_q, beat_count_d;

    assign stall    = out_valid_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        vld_d = vld_q;
        if (!stall) begin
            vld_d[0] = accept;
            for (int k = 1; k < DEPTH; k++) begin
                vld_d[k] = vld_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        fan_out_in_stage #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .hold     (stall),
            .in_data  (in_data),
            .in_en    (in_chan_en[i]),
            .out_data (ch_data[i]),
            .out_en   (ch_en[i])
        );
    end

    // Disabled channels are replaced by the identity so they cannot affect the result
    always_comb begin
        red_val = FILL;
        term    = FILL;
        for (int i = 0; i < N_CHANNELS; i++) begin
            term = ch_en[i] ? ch_data[i] : FILL;
            case (REDUCE_OP)
                OP_AND:  red_val = red_val & term;
                OP_XOR:  red_val = red_val ^ term;
                default: red_val = red_val | term;
            endcase
        end
    end

    // An all-zero mask beat is dropped here: it becomes a bubble and the
    // previous out_data / out_chan_en stay visible.
    assign beat_ok = vld_q[DEPTH-1] && (|ch_en);

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_chan_en_d = out_chan_en_q;
        beat_count_d  = beat_count_q;
        if (!stall) begin
            out_valid_d = beat_ok;
            if (beat_ok) begin
                out_data_d    = red_val;
                out_chan_en_d = ch_en;
            end
        end
        if (out_valid_q && out_ready) begin
            beat_count_d = beat_count_q + BEAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q         <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_chan_en_q <= '0;
            beat_count_q  <= '0;
        end else begin
            vld_q         <= vld_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_chan_en_q <= out_chan_en_d;
            beat_count_q  <= beat_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_chan_en = out_chan_en_q;
    assign beat_count  = beat_count_q;

endmodule
